// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the MMU data-port to AXI4 bridge: AXI burst and
// size encodings and the bridge state enumeration.
package mem_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    AXI_SIZE_1B = 3'd0,
    AXI_SIZE_2B = 3'd1,
    AXI_SIZE_4B = 3'd2
  } axi_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AWW,
    WR_B
  } mem_axi_state_t;

  // The SRAM-side size code maps straight onto the low bits of AXI AxSIZE.
  function automatic axi_size_t to_axi_size(input logic [1:0] size);
    return axi_size_t'({1'b0, size});
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: converts the physical-address SRAM-like request stream
// (req / addr_ok / data_ok) coming out of the MMU data port into single-beat
// AXI4 transactions. One transaction is in flight at a time; read data is
// registered and completion is a one-cycle data_ok pulse.
//
// Optional build macro MEM_AXI_EARLY_WACK_EN: when defined, a store reports
// data_ok as soon as both AW and W have been accepted instead of waiting for
// the B response. The FSM still waits in WR_B for the response before it
// accepts another request.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned AXI_ID   = 1
) (
  input  logic                clk,
  input  logic                reset,
  // SRAM-like request side
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic [31:0]         addr,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  // AXI read-address channel
  output logic [ID_WIDTH-1:0] arid,
  output logic                arvalid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                arready,
  // AXI read-data channel
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata_axi,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write-address channel
  output logic [ID_WIDTH-1:0] awid,
  output logic                awvalid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  input  logic                awready,
  // AXI write-data channel
  output logic [31:0]         wdata_axi,
  output logic [3:0]          wstrb_axi,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write-response channel
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  mem_axi_state_t state;
  mem_axi_state_t state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        we_q;

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;
  logic both_done;
  logic data_ok_next;

  // Response codes and IDs are not used by this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  // Handshake-side outputs are decoded from the state so every valid drops
  // the moment the FSM returns to IDLE, including on reset.
  assign addr_ok = req && (state == IDLE);
  assign arvalid = (state == RD_AR);
  assign rready  = (state == RD_R);
  assign awvalid = (state == WR_AWW) && !aw_done;
  assign wvalid  = (state == WR_AWW) && !w_done;
  assign bready  = (state == WR_B);

  assign arid      = ID_WIDTH'(AXI_ID);
  assign araddr    = addr_q;
  assign arlen     = 8'd0;
  assign arsize    = to_axi_size(size_q);
  assign arburst   = AXI_BURST_INCR;
  assign awid      = ID_WIDTH'(AXI_ID);
  assign awaddr    = addr_q;
  assign awlen     = 8'd0;
  assign awsize    = to_axi_size(size_q);
  assign awburst   = AXI_BURST_INCR;
  assign wdata_axi = wdata_q;
  assign wstrb_axi = wstrb_q;
  assign wlast     = 1'b1;

  // Next-state and completion-pulse decode for the single-outstanding FSM.
  always_comb begin
    state_next   = state;
    data_ok_next = 1'b0;
    aw_hs        = awvalid && awready;
    w_hs         = wvalid && wready;
    both_done    = (aw_done || aw_hs) && (w_done || w_hs);
    case (state)
      IDLE: begin
        if (req) begin
          state_next = we ? WR_AWW : RD_AR;
        end
      end
      RD_AR: begin
        if (arready) begin
          state_next = RD_R;
        end
      end
      RD_R: begin
        if (rvalid) begin
          state_next   = IDLE;
          data_ok_next = !we_q;
        end
      end
      WR_AWW: begin
        if (both_done) begin
          state_next = WR_B;
`ifdef MEM_AXI_EARLY_WACK_EN
          data_ok_next = we_q;
`endif
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_next = IDLE;
`ifndef MEM_AXI_EARLY_WACK_EN
          data_ok_next = we_q;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request fields at acceptance; they drive AXI for the whole transaction.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      addr_q  <= addr;
      size_q  <= size;
      we_q    <= we;
      wstrb_q <= wstrb;
      wdata_q <= wdata;
    end
  end

  // Track AW and W acceptance separately since they may complete in any order.
  always_ff @(posedge clk) begin
    if (reset || (state != WR_AWW)) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
    end
  end

  // Registered load data and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      data_ok <= data_ok_next;
      if ((state == RD_R) && rvalid) begin
        rdata <= rdata_axi;
      end
    end
  end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Testbench for mem_axi_bridge: directed scenarios for load, store, back-to-back,
// backpressure and reset, followed by randomized traffic checked against a
// transaction-level model of the request/AXI protocol.
module tb_mem_axi_bridge;
  import mem_axi_bridge_pkg::*;

  localparam int          ID_WIDTH = 4;
  localparam int unsigned AXI_ID   = 1;
`ifdef MEM_AXI_EARLY_WACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req, we;
  logic [1:0] size;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic addr_ok, data_ok;
  logic [31:0] rdata;
  logic [ID_WIDTH-1:0] arid, rid, awid, bid;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [31:0] araddr, rdata_axi, awaddr, wdata_axi;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb_axi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_axi_bridge #(.ID_WIDTH(ID_WIDTH), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .reset(reset),
    .req(req), .we(we), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = 1'b0; we = 1'b0; size = 2'd0; addr = 32'd0; wstrb = 4'd0; wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'd0; rresp = 2'd0; rlast = 1'b1;
    rid = ID_WIDTH'(AXI_ID); awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bresp = 2'd0; bid = ID_WIDTH'(AXI_ID);
  endtask

  task automatic apply_request(input logic w, input logic [1:0] s, input logic [31:0] a,
                               input logic [3:0] st, input logic [31:0] d);
    req = 1'b1; we = w; size = s; addr = a; wstrb = st; wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (arvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid: got %b expected 0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("[TB] FAIL reset_rready: got %b expected 0", rready); end
    checks++; if (awvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_awvalid: got %b expected 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wvalid: got %b expected 0", wvalid); end
    checks++; if (bready !== 1'b0) begin failures++; $display("[TB] FAIL reset_bready: got %b expected 0", bready); end
    checks++; if (data_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_ok: got %b expected 0", data_ok); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    apply_request(1'b0, 2'd2, 32'h1C00_0104, 4'h0, 32'h0);
    #1;
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL load_addr_ok: got %b expected 1", addr_ok); end
    tick(); req = 1'b0; #1;
    checks++; if (arvalid !== 1'b1) begin failures++; $display("[TB] FAIL load_arvalid: got %b expected 1", arvalid); end
    checks++; if (araddr !== 32'h1C00_0104) begin failures++; $display("[TB] FAIL load_araddr: got %h expected 1c000104", araddr); end
    checks++; if (arsize !== 3'd2) begin failures++; $display("[TB] FAIL load_arsize: got %0d expected 2", arsize); end
    checks++; if ({arlen, arburst, arid} !== {8'd0, 2'b01, 4'd1}) begin failures++; $display("[TB] FAIL load_ar_const: got %h expected %h", {arlen, arburst, arid}, {8'd0, 2'b01, 4'd1}); end
    arready = 1'b1;
    tick(); arready = 1'b0; #1;
    checks++; if ({arvalid, rready, data_ok} !== 3'b010) begin failures++; $display("[TB] FAIL load_rphase: got %b expected 010", {arvalid, rready, data_ok}); end
    rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF;
    tick(); rvalid = 1'b0; #1;
    checks++; if (data_ok !== 1'b1) begin failures++; $display("[TB] FAIL load_data_ok: got %b expected 1", data_ok); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL load_rdata: got %h expected deadbeef", rdata); end
    checks++; if (rready !== 1'b0) begin failures++; $display("[TB] FAIL load_rready_drop: got %b expected 0", rready); end
    tick(); #1;
    checks++; if (data_ok !== 1'b0) begin failures++; $display("[TB] FAIL load_pulse_width: got %b expected 0", data_ok); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL load_rdata_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_byte_store();
    apply_request(1'b1, 2'd0, 32'h0000_0003, 4'b1000, 32'h5A5A_5A5A);
    #1;
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL store_addr_ok: got %b expected 1", addr_ok); end
    tick(); req = 1'b0; #1;
    checks++; if ({awvalid, wvalid, arvalid} !== 3'b110) begin failures++; $display("[TB] FAIL store_valids: got %b expected 110", {awvalid, wvalid, arvalid}); end
    checks++; if ({awaddr, awsize, awlen, awburst, awid} !== {32'h3, 3'd0, 8'd0, 2'b01, 4'd1}) begin failures++; $display("[TB] FAIL store_aw_fields: got %h expected %h", {awaddr, awsize, awlen, awburst, awid}, {32'h3, 3'd0, 8'd0, 2'b01, 4'd1}); end
    checks++; if ({wdata_axi, wstrb_axi, wlast} !== {32'h5A5A_5A5A, 4'b1000, 1'b1}) begin failures++; $display("[TB] FAIL store_w_fields: got %h expected %h", {wdata_axi, wstrb_axi, wlast}, {32'h5A5A_5A5A, 4'b1000, 1'b1}); end
    wready = 1'b1;
    tick(); wready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      awready = (i == 2);
      #1;
      checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin failures++; $display("[TB] FAIL store_w_first_%0d: got %b expected 100", i, {awvalid, wvalid, bready}); end
    end
    tick(); awready = 1'b0; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin failures++; $display("[TB] FAIL store_bphase: got %b expected 001", {awvalid, wvalid, bready}); end
    checks++; if (data_ok !== EARLY) begin failures++; $display("[TB] FAIL store_data_ok_before_b: got %b expected %b", data_ok, EARLY); end
    bvalid = 1'b1;
    tick(); bvalid = 1'b0; #1;
    checks++; if (data_ok !== !EARLY) begin failures++; $display("[TB] FAIL store_data_ok_after_b: got %b expected %b", data_ok, !EARLY); end
    checks++; if (bready !== 1'b0) begin failures++; $display("[TB] FAIL store_bready_drop: got %b expected 0", bready); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL store_rdata_kept: got %h expected deadbeef", rdata); end
    tick(); #1;
    checks++; if (data_ok !== 1'b0) begin failures++; $display("[TB] FAIL store_pulse_width: got %b expected 0", data_ok); end
  endtask

  task automatic test_back_to_back();
    apply_request(1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'h0);
    #1;
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_load_accept: got %b expected 1", addr_ok); end
    tick(); apply_request(1'b1, 2'd2, 32'h0000_2000, 4'hF, 32'h1234_5678); #1;
    checks++; if ({addr_ok, arvalid, awvalid} !== 3'b010) begin failures++; $display("[TB] FAIL b2b_ar_phase: got %b expected 010", {addr_ok, arvalid, awvalid}); end
    arready = 1'b1;
    tick(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D; #1;
    checks++; if ({addr_ok, rready, awvalid} !== 3'b010) begin failures++; $display("[TB] FAIL b2b_r_phase: got %b expected 010", {addr_ok, rready, awvalid}); end
    tick(); rvalid = 1'b0; #1;
    checks++; if ({data_ok, addr_ok, arvalid} !== 3'b110) begin failures++; $display("[TB] FAIL b2b_same_cycle_accept: got %b expected 110", {data_ok, addr_ok, arvalid}); end
    checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL b2b_rdata: got %h expected cafef00d", rdata); end
    tick(); req = 1'b0; #1;
    checks++; if ({awvalid, wvalid, arvalid, data_ok} !== 4'b1100) begin failures++; $display("[TB] FAIL b2b_aw_phase: got %b expected 1100", {awvalid, wvalid, arvalid, data_ok}); end
    checks++; if (awaddr !== 32'h0000_2000) begin failures++; $display("[TB] FAIL b2b_awaddr: got %h expected 00002000", awaddr); end
    awready = 1'b1; wready = 1'b1;
    tick(); awready = 1'b0; wready = 1'b0; #1;
    checks++; if ({bready, data_ok} !== {1'b1, EARLY}) begin failures++; $display("[TB] FAIL b2b_bphase: got %b expected %b", {bready, data_ok}, {1'b1, EARLY}); end
    bvalid = 1'b1;
    tick(); bvalid = 1'b0; #1;
    checks++; if ({bready, data_ok} !== {1'b0, !EARLY}) begin failures++; $display("[TB] FAIL b2b_store_done: got %b expected %b", {bready, data_ok}, {1'b0, !EARLY}); end
    tick();
  endtask

  task automatic test_backpressure();
    apply_request(1'b0, 2'd1, 32'h0000_0042, 4'h0, 32'h0);
    #1;
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept: got %b expected 1", addr_ok); end
    tick(); apply_request(1'b1, 2'd2, 32'h0000_0100, 4'hF, 32'hFFFF_0000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      checks++; if ({arvalid, addr_ok} !== 2'b10) begin failures++; $display("[TB] FAIL bp_stall_%0d: got %b expected 10", i, {arvalid, addr_ok}); end
      checks++; if ({araddr, arsize} !== {32'h42, 3'd1}) begin failures++; $display("[TB] FAIL bp_stable_%0d: got %h expected %h", i, {araddr, arsize}, {32'h42, 3'd1}); end
    end
    tick(); req = 1'b0; arready = 1'b1; #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h42}) begin failures++; $display("[TB] FAIL bp_release: got %h expected %h", {arvalid, araddr}, {1'b1, 32'h42}); end
    tick(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0BAD_CAFE; #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("[TB] FAIL bp_rready: got %b expected 1", rready); end
    tick(); rvalid = 1'b0; #1;
    checks++; if ({data_ok, rdata} !== {1'b1, 32'h0BAD_CAFE}) begin failures++; $display("[TB] FAIL bp_done: got %h expected %h", {data_ok, rdata}, {1'b1, 32'h0BAD_CAFE}); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    apply_request(1'b0, 2'd2, 32'h0000_0200, 4'h0, 32'h0);
    #1;
    tick(); req = 1'b0; arready = 1'b1; #1;
    checks++; if (arvalid !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_arvalid: got %b expected 1", arvalid); end
    tick(); arready = 1'b0; #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_in_rphase: got %b expected 1", rready); end
    reset = 1'b1;
    tick(); reset = 1'b0;
    apply_request(1'b1, 2'd2, 32'h0000_0300, 4'h3, 32'h0000_ABCD); #1;
    checks++; if ({arvalid, rready, awvalid, data_ok} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_mid_outputs: got %b expected 0000", {arvalid, rready, awvalid, data_ok}); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_rdata: got %h expected 0", rdata); end
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_new_accept: got %b expected 1", addr_ok); end
    tick(); req = 1'b0; #1;
    checks++; if ({data_ok, awvalid, wvalid, awaddr} !== {3'b011, 32'h300}) begin failures++; $display("[TB] FAIL rst_mid_store: got %h expected %h", {data_ok, awvalid, wvalid, awaddr}, {3'b011, 32'h300}); end
    awready = 1'b1; wready = 1'b1;
    tick(); awready = 1'b0; wready = 1'b0; #1;
    checks++; if (bready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_bready: got %b expected 1", bready); end
    bvalid = 1'b1;
    tick(); bvalid = 1'b0; #1;
    tick();
  endtask

`ifdef MEM_AXI_EARLY_WACK_EN
  task automatic test_early_wack();
    apply_request(1'b1, 2'd2, 32'h0000_0400, 4'hF, 32'h8765_4321);
    #1;
    tick(); req = 1'b0; awready = 1'b1; wready = 1'b1; #1;
    checks++; if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("[TB] FAIL early_valids: got %b expected 11", {awvalid, wvalid}); end
    tick(); awready = 1'b0; wready = 1'b0;
    apply_request(1'b0, 2'd2, 32'h0000_0500, 4'h0, 32'h0); #1;
    checks++; if ({data_ok, bready, addr_ok} !== 3'b110) begin failures++; $display("[TB] FAIL early_ack: got %b expected 110", {data_ok, bready, addr_ok}); end
    for (int i = 0; i < 4; i++) begin
      tick(); bvalid = (i == 3); #1;
      checks++; if ({data_ok, bready, addr_ok} !== 3'b010) begin failures++; $display("[TB] FAIL early_wait_b_%0d: got %b expected 010", i, {data_ok, bready, addr_ok}); end
    end
    tick(); bvalid = 1'b0; #1;
    checks++; if ({addr_ok, data_ok, bready} !== 3'b100) begin failures++; $display("[TB] FAIL early_after_b: got %b expected 100", {addr_ok, data_ok, bready}); end
    tick(); req = 1'b0; #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h500}) begin failures++; $display("[TB] FAIL early_next_load: got %h expected %h", {arvalid, araddr}, {1'b1, 32'h500}); end
    arready = 1'b1;
    tick(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h1111_2222; #1;
    tick(); rvalid = 1'b0; #1;
    checks++; if ({data_ok, rdata} !== {1'b1, 32'h1111_2222}) begin failures++; $display("[TB] FAIL early_load_done: got %h expected %h", {data_ok, rdata}, {1'b1, 32'h1111_2222}); end
    tick();
  endtask
`endif

  // Random traffic against a transaction-level model: each accepted request is
  // one open transaction whose AR (load) or AW+W (store) must be offered until
  // accepted, followed by its response, then a completion pulse one cycle later.
  task automatic test_random(input int n_txn);
    bit busy, m_we, ar_d, aw_d, w_d, have_req, exp_dok, accept;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, early_done;
    bit q_we;
    logic [1:0] q_size, m_size;
    logic [31:0] q_addr, q_wdata, m_addr, m_wdata, exp_rdata;
    logic [3:0] q_wstrb, m_wstrb;
    int issued, done, cyc;
    busy = 0; m_we = 0; ar_d = 0; aw_d = 0; w_d = 0; have_req = 0; exp_dok = 0;
    q_we = 0; q_size = 0; q_addr = 0; q_wdata = 0; q_wstrb = 0;
    m_size = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; exp_rdata = 32'd0;
    issued = 0; done = 0; cyc = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    while (done < n_txn && cyc < 100 * n_txn) begin
      if (!have_req && issued < n_txn && $urandom_range(0, 1) == 1) begin
        q_we = 1'($urandom_range(0, 1)); q_size = 2'($urandom_range(0, 2));
        q_addr = $urandom; q_wstrb = 4'($urandom); q_wdata = $urandom;
        have_req = 1; issued++;
      end
      req = have_req; we = q_we; size = q_size; addr = q_addr; wstrb = q_wstrb; wdata = q_wdata;
      arready = ($urandom_range(0, 2) != 0);
      awready = ($urandom_range(0, 2) != 0);
      wready = ($urandom_range(0, 2) != 0);
      rvalid = busy && !m_we && ar_d && ($urandom_range(0, 2) == 0);
      rdata_axi = $urandom; rresp = 2'($urandom); rid = 4'($urandom);
      bvalid = busy && m_we && aw_d && w_d && ($urandom_range(0, 2) == 0);
      bresp = 2'($urandom); bid = 4'($urandom);
      #1;
      checks++; if (addr_ok !== (have_req && !busy)) begin failures++; $display("[TB] FAIL rnd_addr_ok c%0d: got %b expected %b", cyc, addr_ok, have_req && !busy); end
      checks++; if ({arvalid, rready} !== {busy && !m_we && !ar_d, busy && !m_we && ar_d}) begin failures++; $display("[TB] FAIL rnd_read_ctl c%0d: got %b expected %b", cyc, {arvalid, rready}, {busy && !m_we && !ar_d, busy && !m_we && ar_d}); end
      checks++; if ({awvalid, wvalid, bready} !== {busy && m_we && !aw_d, busy && m_we && !w_d, busy && m_we && aw_d && w_d}) begin failures++; $display("[TB] FAIL rnd_write_ctl c%0d: got %b expected %b", cyc, {awvalid, wvalid, bready}, {busy && m_we && !aw_d, busy && m_we && !w_d, busy && m_we && aw_d && w_d}); end
      checks++; if (data_ok !== exp_dok) begin failures++; $display("[TB] FAIL rnd_data_ok c%0d: got %b expected %b", cyc, data_ok, exp_dok); end
      checks++; if (rdata !== exp_rdata) begin failures++; $display("[TB] FAIL rnd_rdata c%0d: got %h expected %h", cyc, rdata, exp_rdata); end
      ar_hs = busy && !m_we && !ar_d && arready;
      r_hs  = busy && !m_we && ar_d && rvalid;
      aw_hs = busy && m_we && !aw_d && awready;
      w_hs  = busy && m_we && !w_d && wready;
      b_hs  = busy && m_we && aw_d && w_d && bvalid;
      early_done = busy && m_we && !(aw_d && w_d) && (aw_d || aw_hs) && (w_d || w_hs);
      if (ar_hs) begin
        checks++; if ({araddr, arsize, arlen, arburst, arid} !== {m_addr, 1'b0, m_size, 8'd0, 2'b01, 4'd1}) begin failures++; $display("[TB] FAIL rnd_ar_fields c%0d: got %h expected %h", cyc, {araddr, arsize, arlen, arburst, arid}, {m_addr, 1'b0, m_size, 8'd0, 2'b01, 4'd1}); end
      end
      if (aw_hs) begin
        checks++; if ({awaddr, awsize, awlen, awburst, awid} !== {m_addr, 1'b0, m_size, 8'd0, 2'b01, 4'd1}) begin failures++; $display("[TB] FAIL rnd_aw_fields c%0d: got %h expected %h", cyc, {awaddr, awsize, awlen, awburst, awid}, {m_addr, 1'b0, m_size, 8'd0, 2'b01, 4'd1}); end
      end
      if (w_hs) begin
        checks++; if ({wdata_axi, wstrb_axi, wlast} !== {m_wdata, m_wstrb, 1'b1}) begin failures++; $display("[TB] FAIL rnd_w_fields c%0d: got %h expected %h", cyc, {wdata_axi, wstrb_axi, wlast}, {m_wdata, m_wstrb, 1'b1}); end
      end
      accept = have_req && !busy;
      exp_dok = r_hs || (EARLY ? early_done : b_hs);
      if (r_hs) exp_rdata = rdata_axi;
      if (ar_hs) ar_d = 1;
      if (aw_hs) aw_d = 1;
      if (w_hs) w_d = 1;
      if (r_hs || b_hs) begin
        busy = 0;
        done++;
      end
      if (accept) begin
        busy = 1; have_req = 0;
        m_we = q_we; m_size = q_size; m_addr = q_addr; m_wstrb = q_wstrb; m_wdata = q_wdata;
        ar_d = 0; aw_d = 0; w_d = 0;
      end
      tick();
      cyc++;
    end
    checks++; if (done != n_txn) begin failures++; $display("[TB] FAIL rnd_timeout: completed %0d expected %0d", done, n_txn); end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_word_load();
    test_byte_store();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_read();
`ifdef MEM_AXI_EARLY_WACK_EN
    test_early_wack();
`endif
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
